arm7_load_store_unit: RTL and testbench

Initiator side of the ARM7 data-memory interface. It accepts LDR/STR/LDRB/STRB requests from the execute stage over a valid/ready handshake and drives the data_memory word and byte read/write ports. It waits out the memory read latency and returns load data to writeback, with ARM7 unaligned-word rotation and byte zero-extension applied.

---
 rtl/arm7_load_store_unit.sv | 192 +++++++++++++++++++
 tb/tb_arm7_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm7_load_store_unit.sv
// Purpose  : ARM7 data-memory initiator; executes LDR/STR/LDRB/STRB against data_memory.
// Latency  : store resp 2 cycles after accept, load resp 2 + MEM_RD_LATENCY cycles after accept.
// Backpres.: req_ready low while a request is in ISSUE/WAIT; responses are never stalled.
//
// Optional feature macro: LSU_ALIGN_FAULT_EN
//   defined   -> unaligned word accesses abort (no memory access, resp in cycle 1, resp_abort=1)
//   undefined -> unaligned word loads rotate, unaligned word stores align; resp_abort tied 0
//
// Ports:
//   clk, rst_n                       clock and async active-low reset
//   req_valid/req_ready              request handshake from execute
//   req_load/byte/addr/wdata/rd      request fields (rd is a tag echoed on resp_rd)
//   resp_valid/rdata/rd/abort        one-cycle completion to writeback
//   mem_*                            data_memory word/byte read/write ports

module arm7_load_store_unit #(
   parameter int MEM_RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_byte,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_rd,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [3:0]  resp_rd,
   output logic        resp_abort,
   output logic        mem_write_word_en,
   output logic        mem_write_byte_en,
   output logic        mem_read_word_en,
   output logic        mem_read_byte_en,
   output logic [31:0] mem_write_word_address,
   output logic [31:0] mem_write_byte_address,
   output logic [31:0] mem_write_word_data,
   output logic [7:0]  mem_write_byte_data,
   output logic [31:0] mem_read_word_address,
   output logic [31:0] mem_read_byte_address,
   input  logic [31:0] mem_read_word_data,
   input  logic [7:0]  mem_read_byte_data
);

   localparam int CW = $clog2(MEM_RD_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic           load_q,  load_d;
   logic           byte_q,  byte_d;
   logic [31:0]    addr_q,  addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [3:0]     rd_q,    rd_d;
   logic [31:0]    rdata_q, rdata_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
`ifdef LSU_ALIGN_FAULT_EN
   logic           abort_q, abort_d;
`endif

   logic           accept;
   logic           issue;
   logic [31:0]    word_rot;
   logic [31:0]    word_addr;

   // Ready is gated by rst_n so it reads 0 combinationally while reset is held.
   assign req_ready = rst_n && (state_q == IDLE || state_q == RESP);
   assign accept    = req_valid && req_ready;
   assign issue     = (state_q == ISSUE);
   assign word_addr = {addr_q[31:2], 2'b00};

   // ARM7 LDR from an unaligned address returns the aligned word rotated right
   // so the addressed byte lands in bits [7:0].
   always_comb begin
      word_rot = mem_read_word_data;
      case (addr_q[1:0])
         2'd1:    word_rot = {mem_read_word_data[7:0],  mem_read_word_data[31:8]};
         2'd2:    word_rot = {mem_read_word_data[15:0], mem_read_word_data[31:16]};
         2'd3:    word_rot = {mem_read_word_data[23:0], mem_read_word_data[31:24]};
         default: word_rot = mem_read_word_data;
      endcase
   end

   always_comb begin
      state_d = state_q;
      load_d  = load_q;
      byte_d  = byte_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
`ifdef LSU_ALIGN_FAULT_EN
      abort_d = abort_q;
`endif
      case (state_q)
         ISSUE: begin
            if (load_q) begin
               state_d = WAIT;
               cnt_d   = CW'(MEM_RD_LATENCY);
            end else begin
               state_d = RESP;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = RESP;
               rdata_d = byte_q ? {24'b0, mem_read_byte_data} : word_rot;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = state_q;
      endcase

      // Accept only happens in IDLE or RESP, so it overrides the case above.
      if (accept) begin
         load_d  = req_load;
         byte_d  = req_byte;
         addr_d  = req_addr;
         wdata_d = req_wdata;
         rd_d    = req_rd;
         rdata_d = 32'b0;
         state_d = ISSUE;
`ifdef LSU_ALIGN_FAULT_EN
         abort_d = 1'b0;
         if (!req_byte && (req_addr[1:0] != 2'b00)) begin
            abort_d = 1'b1;
            state_d = RESP;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         load_q  <= 1'b0;
         byte_q  <= 1'b0;
         addr_q  <= 32'b0;
         wdata_q <= 32'b0;
         rd_q    <= 4'b0;
         rdata_q <= 32'b0;
         cnt_q   <= '0;
`ifdef LSU_ALIGN_FAULT_EN
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
         byte_q  <= byte_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
`ifdef LSU_ALIGN_FAULT_EN
         abort_q <= abort_d;
`endif
      end
   end

   // Memory side: enables only in ISSUE, address/data buses zero when not enabled.
   assign mem_write_word_en      = issue && !load_q && !byte_q;
   assign mem_write_byte_en      = issue && !load_q &&  byte_q;
   assign mem_read_word_en       = issue &&  load_q && !byte_q;
   assign mem_read_byte_en       = issue &&  load_q &&  byte_q;

   assign mem_write_word_address = mem_write_word_en ? word_addr      : 32'b0;
   assign mem_write_word_data    = mem_write_word_en ? wdata_q        : 32'b0;
   assign mem_write_byte_address = mem_write_byte_en ? addr_q         : 32'b0;
   assign mem_write_byte_data    = mem_write_byte_en ? wdata_q[7:0]   : 8'b0;
   assign mem_read_word_address  = mem_read_word_en  ? word_addr      : 32'b0;
   assign mem_read_byte_address  = mem_read_byte_en  ? addr_q         : 32'b0;

   // Response side.
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_valid ? rdata_q : 32'b0;
   assign resp_rd    = resp_valid ? rd_q    : 4'b0;
`ifdef LSU_ALIGN_FAULT_EN
   assign resp_abort = resp_valid && abort_q;
`else
   assign resp_abort = 1'b0;
`endif

endmodule

// File: tb/tb_arm7_load_store_unit.sv
// Directed bench for arm7_load_store_unit: instance A (latency 1) runs against a
// small word/byte memory model, instance B (latency 3) against a synthetic read pipe.
module tb_arm7_load_store_unit;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- instance A (MEM_RD_LATENCY = 1) ----------------
   logic        a_req_valid, a_req_ready, a_req_load, a_req_byte;
   logic [31:0] a_req_addr, a_req_wdata;
   logic [3:0]  a_req_rd;
   logic        a_resp_valid, a_resp_abort;
   logic [31:0] a_resp_rdata;
   logic [3:0]  a_resp_rd;
   logic        a_wwe, a_wbe, a_rwe, a_rbe;
   logic [31:0] a_wwa, a_wba, a_wwd, a_rwa, a_rba;
   logic [7:0]  a_wbd;
   logic [31:0] a_rword;
   logic [7:0]  a_rbyte;
   logic [3:0]  a_en;
   logic        a_any;

   assign a_en  = {a_wwe, a_wbe, a_rwe, a_rbe};
   assign a_any = |{a_req_ready, a_resp_valid, a_resp_rdata, a_resp_rd, a_resp_abort,
                    a_en, a_wwa, a_wba, a_wwd, a_wbd, a_rwa, a_rba};

   arm7_load_store_unit #(.MEM_RD_LATENCY(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_load(a_req_load),
      .req_byte(a_req_byte), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_rd(a_req_rd),
      .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_rd(a_resp_rd),
      .resp_abort(a_resp_abort),
      .mem_write_word_en(a_wwe), .mem_write_byte_en(a_wbe),
      .mem_read_word_en(a_rwe), .mem_read_byte_en(a_rbe),
      .mem_write_word_address(a_wwa), .mem_write_byte_address(a_wba),
      .mem_write_word_data(a_wwd), .mem_write_byte_data(a_wbd),
      .mem_read_word_address(a_rwa), .mem_read_byte_address(a_rba),
      .mem_read_word_data(a_rword), .mem_read_byte_data(a_rbyte)
   );

   // Memory model for A: writes on the edge, reads registered (latency 1).
   logic [31:0] mem_a [0:1023];
   always @(posedge clk) begin
      if (a_wwe) mem_a[a_wwa[11:2]] <= a_wwd;
      if (a_wbe) mem_a[a_wba[11:2]][8*a_wba[1:0] +: 8] <= a_wbd;
      a_rword <= a_rwe ? mem_a[a_rwa[11:2]] : 32'h0;
      a_rbyte <= a_rbe ? 8'(mem_a[a_rba[11:2]] >> (8*a_rba[1:0])) : 8'h0;
   end

   // ---------------- instance B (MEM_RD_LATENCY = 3) ----------------
   logic        b_req_valid, b_req_ready, b_req_load, b_req_byte;
   logic [31:0] b_req_addr, b_req_wdata;
   logic [3:0]  b_req_rd;
   logic        b_resp_valid, b_resp_abort;
   logic [31:0] b_resp_rdata;
   logic [3:0]  b_resp_rd;
   logic        b_wwe, b_wbe, b_rwe, b_rbe;
   logic [31:0] b_wwa, b_wba, b_wwd, b_rwa, b_rba;
   logic [7:0]  b_wbd;
   logic [31:0] b_s0, b_s1, b_s2;
   logic [7:0]  b_rbyte;
   assign b_rbyte = 8'h0;

   arm7_load_store_unit #(.MEM_RD_LATENCY(3)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_load(b_req_load),
      .req_byte(b_req_byte), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_rd(b_req_rd),
      .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_rd(b_resp_rd),
      .resp_abort(b_resp_abort),
      .mem_write_word_en(b_wwe), .mem_write_byte_en(b_wbe),
      .mem_read_word_en(b_rwe), .mem_read_byte_en(b_rbe),
      .mem_write_word_address(b_wwa), .mem_write_byte_address(b_wba),
      .mem_write_word_data(b_wwd), .mem_write_byte_data(b_wbd),
      .mem_read_word_address(b_rwa), .mem_read_byte_address(b_rba),
      .mem_read_word_data(b_s2), .mem_read_byte_data(b_rbyte)
   );

   // Three-stage read pipe: word at address X reads back as {X[15:0], 16'hC0DE}.
   always @(posedge clk) begin
      b_s0 <= b_rwe ? {b_rwa[15:0], 16'hC0DE} : 32'h0;
      b_s1 <= b_s0;
      b_s2 <= b_s1;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic a_req(input logic ld, input logic by, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] rd);
      a_req_load  = ld;
      a_req_byte  = by;
      a_req_addr  = addr;
      a_req_wdata = wd;
      a_req_rd    = rd;
      a_req_valid = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic seen;
      rst_n = 1'b0;
      a_req_valid = 0; a_req_load = 0; a_req_byte = 0; a_req_addr = 0; a_req_wdata = 0; a_req_rd = 0;
      b_req_valid = 0; b_req_load = 0; b_req_byte = 0; b_req_addr = 0; b_req_wdata = 0; b_req_rd = 0;

      // Reset state
      #2;
      chk("reset_outputs_zero", 32'(a_any), 32'h0);
      chk("reset_ready_b", 32'(b_req_ready), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_after_release", 32'(a_req_ready), 32'h1);

      // STR 0xDEADBEEF @0x1000
      @(negedge clk); a_req(1'b0, 1'b0, 32'h1000, 32'hDEADBEEF, 4'd3);
      chk("str_ready_c0", 32'(a_req_ready), 32'h1);
      @(negedge clk); a_req_valid = 1'b0;
      chk("str_en_c1", 32'(a_en), 32'h8);
      chk("str_addr", a_wwa, 32'h1000);
      chk("str_data", a_wwd, 32'hDEADBEEF);
      chk("str_resp_c1", 32'(a_resp_valid), 32'h0);
      chk("str_ready_c1", 32'(a_req_ready), 32'h0);
      @(negedge clk);
      chk("str_resp_c2", 32'(a_resp_valid), 32'h1);
      chk("str_rdata", a_resp_rdata, 32'h0);
      chk("str_rd", 32'(a_resp_rd), 32'h3);
      chk("str_en_c2", 32'(a_en), 32'h0);
      chk("str_addr_c2_zero", a_wwa, 32'h0);

      // LDR @0x1000, rd=5
      @(negedge clk); a_req(1'b1, 1'b0, 32'h1000, 32'h0, 4'd5);
      @(negedge clk); a_req_valid = 1'b0;
      chk("ldr_en_c1", 32'(a_en), 32'h2);
      chk("ldr_addr", a_rwa, 32'h1000);
      @(negedge clk);
      chk("ldr_resp_c2", 32'(a_resp_valid), 32'h0);
      @(negedge clk);
      chk("ldr_resp_c3", 32'(a_resp_valid), 32'h1);
      chk("ldr_rdata", a_resp_rdata, 32'hDEADBEEF);
      chk("ldr_rd", 32'(a_resp_rd), 32'h5);

      // STRB 0xAA @0x1001, then STRB 0x55 @0x1003 presented during RESP
      @(negedge clk); a_req(1'b0, 1'b1, 32'h1001, 32'h123456AA, 4'd1);
      @(negedge clk); a_req_valid = 1'b0;
      chk("strb1_en", 32'(a_en), 32'h4);
      chk("strb1_addr", a_wba, 32'h1001);
      chk("strb1_data", 32'(a_wbd), 32'hAA);
      @(negedge clk);
      chk("strb1_resp", 32'(a_resp_valid), 32'h1);
      chk("strb1_ready_in_resp", 32'(a_req_ready), 32'h1);
      a_req(1'b0, 1'b1, 32'h1003, 32'hFFFFFF55, 4'd2);
      @(negedge clk); a_req_valid = 1'b0;
      chk("strb2_en", 32'(a_en), 32'h4);
      chk("strb2_addr", a_wba, 32'h1003);
      chk("strb2_data", 32'(a_wbd), 32'h55);
      @(negedge clk);
      chk("strb2_resp", 32'(a_resp_valid), 32'h1);
      chk("strb2_rd", 32'(a_resp_rd), 32'h2);

      // LDRB @0x1001 and @0x1003
      @(negedge clk); a_req(1'b1, 1'b1, 32'h1001, 32'h0, 4'd8);
      @(negedge clk); a_req_valid = 1'b0;
      chk("ldrb1_en", 32'(a_en), 32'h1);
      chk("ldrb1_addr", a_rba, 32'h1001);
      @(negedge clk);
      @(negedge clk);
      chk("ldrb1_resp", 32'(a_resp_valid), 32'h1);
      chk("ldrb1_rdata", a_resp_rdata, 32'h000000AA);
      chk("ldrb1_rd", 32'(a_resp_rd), 32'h8);
      @(negedge clk); a_req(1'b1, 1'b1, 32'h1003, 32'h0, 4'd10);
      @(negedge clk); a_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ldrb2_resp", 32'(a_resp_valid), 32'h1);
      chk("ldrb2_rdata", a_resp_rdata, 32'h00000055);

      // LDR @0x1001 (memory word now 0x55ADAAEF)
      @(negedge clk); a_req(1'b1, 1'b0, 32'h1001, 32'h0, 4'd7);
      @(negedge clk); a_req_valid = 1'b0;
`ifdef LSU_ALIGN_FAULT_EN
      chk("unal_ldr_en", 32'(a_en), 32'h0);
      chk("unal_ldr_resp_c1", 32'(a_resp_valid), 32'h1);
      chk("unal_ldr_abort", 32'(a_resp_abort), 32'h1);
      chk("unal_ldr_rdata", a_resp_rdata, 32'h0);
      chk("unal_ldr_rd", 32'(a_resp_rd), 32'h7);
      @(negedge clk);
      chk("unal_ldr_resp_c2", 32'(a_resp_valid), 32'h0);
      chk("unal_ldr_en_c2", 32'(a_en), 32'h0);
`else
      chk("unal_ldr_en", 32'(a_en), 32'h2);
      chk("unal_ldr_addr", a_rwa, 32'h1000);
      @(negedge clk);
      @(negedge clk);
      chk("unal_ldr_resp", 32'(a_resp_valid), 32'h1);
      chk("unal_ldr_rdata", a_resp_rdata, 32'hEF55ADAA);
      chk("unal_ldr_abort", 32'(a_resp_abort), 32'h0);
      // Unaligned STR: address aligned, data not rotated
      @(negedge clk); a_req(1'b0, 1'b0, 32'h1002, 32'h12345678, 4'd1);
      @(negedge clk); a_req_valid = 1'b0;
      chk("unal_str_en", 32'(a_en), 32'h8);
      chk("unal_str_addr", a_wwa, 32'h1000);
      chk("unal_str_data", a_wwd, 32'h12345678);
      @(negedge clk);
      chk("unal_str_resp", 32'(a_resp_valid), 32'h1);
`endif

      // Reset pulse during WAIT of a load
      @(negedge clk); a_req(1'b1, 1'b0, 32'h1000, 32'h0, 4'd9);
      @(negedge clk); a_req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_wait_outputs_zero", 32'(a_any), 32'h0);
      @(negedge clk);
      chk("rst_held_outputs_zero", 32'(a_any), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rst_ready_after_release", 32'(a_req_ready), 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen = seen | a_resp_valid | (|a_en);
      end
      chk("rst_inflight_dropped", 32'(seen), 32'h0);

      // Instance B: latency 3, back-to-back loads one response every 5 cycles
      @(negedge clk);
      b_req_load = 1'b1; b_req_byte = 1'b0; b_req_addr = 32'h2004; b_req_rd = 4'd4;
      b_req_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) b_req_valid = 1'b0;
         chk($sformatf("b_resp_valid_c%0d", k), 32'(b_resp_valid),
             (k == 5 || k == 10) ? 32'h1 : 32'h0);
         if (k == 5) begin
            chk("b_ldr1_rdata", b_resp_rdata, 32'h2004C0DE);
            chk("b_ldr1_rd", 32'(b_resp_rd), 32'h4);
            b_req_addr = 32'h2008; b_req_rd = 4'd6; b_req_valid = 1'b1;
         end
         if (k == 6) begin
            b_req_valid = 1'b0;
            chk("b_ldr2_en", 32'(b_rwe), 32'h1);
            chk("b_ldr2_addr", b_rwa, 32'h2008);
         end
         if (k == 10) begin
            chk("b_ldr2_rdata", b_resp_rdata, 32'h2008C0DE);
            chk("b_ldr2_rd", 32'(b_resp_rd), 32'h6);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
